// File: rtl/regfile_write_ctrl_pkg.sv
// Shared types and constants for the register-file write-side controller.
// Widths of a register, register address, and the buffered-load entry record.
// Imported by wb_load_fifo and regfile_write_ctrl.
package regfile_write_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // One buffered load return. 'live' drops when a younger ALU write to the
  // same register kills it or when the slot is popped.
  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_ctrl_wb_load_fifo.sv
// Load-return buffer: circular FIFO of wb_entry_t with kill-by-destination.
// Latency: push visible at head the next cycle; pop/kill take effect at the edge.
// Backpressure: o_full tells the caller to refuse pushes; push while full is not expected.
// Ports: CLK/RESET; i_push/i_push_dest/i_push_data; i_pop; i_kill_vld/i_kill_dest;
//        o_head (current head entry), o_empty, o_full, o_pend_mask (live dest decode).
module wb_load_fifo
  import regfile_write_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                i_push,
  input  logic [ADDR_W-1:0]   i_push_dest,
  input  logic [DATA_W-1:0]   i_push_data,
  input  logic                i_pop,
  input  logic                i_kill_vld,
  input  logic [ADDR_W-1:0]   i_kill_dest,
  output wb_entry_t           o_head,
  output logic                o_empty,
  output logic                o_full,
  output logic [NUM_REGS-1:0] o_pend_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [NUM_REGS-1:0]  w_pend_mask;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Kill first; a pop or push landing on the same slot overrides below.
      if (i_kill_vld) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_mem[i].dest == i_kill_dest) begin
            r_mem[i].live <= 1'b0;
          end
        end
      end
      // Popped slots are marked dead so the pending decode only needs 'live'.
      if (i_pop) begin
        r_mem[r_rd_ptr].live <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= '{live: 1'b1, dest: i_push_dest, data: i_push_data};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Pure decode of registered entry state, so it only moves on posedge.
  always_comb begin
    w_pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].live) begin
        w_pend_mask[r_mem[i].dest] = 1'b1;
      end
    end
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_pend_mask = w_pend_mask;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write port arbiter: ALU results first, then buffered loads, then load bypass.
// Latency: ALU 1 cycle; load 1 cycle when bypassed, else 1 + queue position + ALU stalls.
// Backpressure: ld_ready low when the load buffer is full; ALU path is never stalled.
// Ports: CLK/RESET; alu_valid/alu_dest/alu_data; ld_valid/ld_dest/ld_data/ld_ready;
//        RegWr/Writad/Writedata (registered write port); pend_mask (live buffered loads).
module regfile_write_ctrl
  import regfile_write_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_valid,
  input  logic [ADDR_W-1:0]   ld_dest,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                ld_ready,
  output logic                RegWr,
  output logic [ADDR_W-1:0]   Writad,
  output logic [DATA_W-1:0]   Writedata,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic              r_regwr;
  logic [ADDR_W-1:0] r_writad;
  logic [DATA_W-1:0] r_writedata;

  wb_entry_t         w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_alu_take;
  logic              w_ld_acc;
  logic              w_ld_killed;
  logic              w_pop;
  logic              w_bypass;
  logic              w_push;

  // Writes to r0 are architecturally discarded, so an ALU op to r0 frees the slot.
  assign w_alu_take  = alu_valid && (alu_dest != REG_ZERO);
  // ld_ready uses the pre-pop count: a full buffer refuses a load even while draining.
  assign ld_ready    = !w_full;
  assign w_ld_acc    = ld_valid && ld_ready && (ld_dest != REG_ZERO);
  // Same-cycle ALU write to the same register is younger; the load is stale.
  assign w_ld_killed = w_alu_take && (ld_dest == alu_dest);
  assign w_pop       = !w_alu_take && !w_empty;
  // Bypass only with an empty buffer, so older buffered loads are never overtaken.
  assign w_bypass    = !w_alu_take && w_empty && w_ld_acc;
  assign w_push      = w_ld_acc && !w_ld_killed && !w_bypass;

  wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_push      (w_push),
    .i_push_dest (ld_dest),
    .i_push_data (ld_data),
    .i_pop       (w_pop),
    .i_kill_vld  (w_alu_take),
    .i_kill_dest (alu_dest),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_pend_mask (pend_mask)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_regwr     <= 1'b0;
      r_writad    <= '0;
      r_writedata <= '0;
    end else if (w_alu_take) begin
      r_regwr     <= 1'b1;
      r_writad    <= alu_dest;
      r_writedata <= alu_data;
    end else if (!w_empty) begin
      // A dead head still consumes the slot but produces no write.
      r_regwr <= w_head.live;
      if (w_head.live) begin
        r_writad    <= w_head.dest;
        r_writedata <= w_head.data;
      end
    end else if (w_bypass) begin
      r_regwr     <= 1'b1;
      r_writad    <= ld_dest;
      r_writedata <= ld_data;
    end else begin
      r_regwr <= 1'b0;
    end
  end

  assign RegWr     = r_regwr;
  assign Writad    = r_writad;
  assign Writedata = r_writedata;

endmodule
